// File: rtl/clk_div_prog.sv
// clk_div_prog: free-running division counter, NCH programmable square-wave
// channels, a glitch-free CPU clock-enable selector and a debounced single-step
// source for the CPU board clock tree.
module clk_div_prog #(
    parameter int               CNT_W    = 32,
    parameter int               NCH      = 2,
    parameter int               CH_W     = 1,
    parameter int               DIV_W    = 16,
    parameter logic [DIV_W-1:0] DIV_INIT = DIV_W'(3),
    parameter int               DEB_CYC  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cnt_en,
    input  logic             cfg_we,
    input  logic [CH_W-1:0]  cfg_ch,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [CH_W-1:0]  cpu_sel,
    input  logic             step_mode,
    input  logic             step,
    output logic [CNT_W-1:0] clkdiv,
    output logic [NCH-1:0]   ch_clk,
    output logic [NCH-1:0]   ch_tick,
    output logic             cpu_ce,
    output logic             cpu_clk,
    output logic [CH_W-1:0]  sel_cur
);

    // Index space reachable by a CH_W-bit selector; unused slots read as zero.
    localparam int NSEL = 1 << CH_W;
    localparam int DC_W = $clog2(DEB_CYC) + 1;

    logic [NCH-1:0]  tick_nxt;
    logic [NSEL-1:0] tick_nxt_ext;
    logic [NSEL-1:0] tick_ext;
    logic [NSEL-1:0] clk_ext;
    logic [NSEL-1:0] ch_ok;

    logic            step_s1;
    logic            step_s2;
    logic            deb;
    logic            deb_prev;
    logic [DC_W-1:0] deb_cnt;
    logic            step_ce;

    // Pad the per-channel vectors out to the full selector range so that an
    // out-of-range cpu_sel simply sees an invalid, never-ticking channel.
    for (genvar k = 0; k < NSEL; k++) begin : g_ext
        if (k < NCH) begin : g_real
            assign tick_nxt_ext[k] = tick_nxt[k];
            assign tick_ext[k]     = ch_tick[k];
            assign clk_ext[k]      = ch_clk[k];
            assign ch_ok[k]        = 1'b1;
        end else begin : g_pad
            assign tick_nxt_ext[k] = 1'b0;
            assign tick_ext[k]     = 1'b0;
            assign clk_ext[k]      = 1'b0;
            assign ch_ok[k]        = 1'b0;
        end
    end

    // Free-running division counter, paused while cnt_en is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clkdiv <= '0;
        end else if (cnt_en) begin
            clkdiv <= clkdiv + CNT_W'(1);
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [DIV_W-1:0] cnt_q;
        logic [DIV_W-1:0] div_q;
        logic [DIV_W-1:0] pend_q;
        logic             pend_vld;
        logic             clk_q;
        logic             tick_q;
        logic             wr_hit;

        // A channel index outside 0..NCH-1 matches no channel and is dropped.
        assign wr_hit      = cfg_we && (cfg_ch == CH_W'(i));
        // Terminal count at the end of a low phase: the wave rises on this edge.
        assign tick_nxt[i] = cnt_en && (cnt_q == div_q) && !clk_q;
        assign ch_clk[i]   = clk_q;
        assign ch_tick[i]  = tick_q;

        // Half-period counter, toggling wave, rise tick and a pending divisor
        // that is only swapped in at a rising edge so no phase is ever cut.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q    <= '0;
                div_q    <= DIV_INIT;
                pend_q   <= '0;
                pend_vld <= 1'b0;
                clk_q    <= 1'b0;
                tick_q   <= 1'b0;
            end else begin
                if (cnt_en) begin
                    if (cnt_q == div_q) begin
                        cnt_q <= '0;
                        clk_q <= ~clk_q;
                    end else begin
                        cnt_q <= cnt_q + DIV_W'(1);
                    end
                end
                tick_q <= tick_nxt[i];
                if (tick_nxt[i] && pend_vld) begin
                    div_q <= pend_q;
                end
                if (wr_hit) begin
                    pend_q   <= cfg_div;
                    pend_vld <= 1'b1;
                end else if (tick_nxt[i]) begin
                    pend_vld <= 1'b0;
                end
            end
        end
    end

    // Switch source on the edge where the requested channel rises, so the
    // new channel's first tick is already the one driving cpu_ce.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_cur <= '0;
        end else if (ch_ok[cpu_sel] && (cpu_sel != sel_cur) && tick_nxt_ext[cpu_sel]) begin
            sel_cur <= cpu_sel;
        end
    end

    // Synchronise and debounce the step button, then mark each debounced rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_s1  <= 1'b0;
            step_s2  <= 1'b0;
            deb      <= 1'b0;
            deb_prev <= 1'b0;
            deb_cnt  <= '0;
            step_ce  <= 1'b0;
        end else begin
            step_s1 <= step;
            step_s2 <= step_s1;
            if (step_s2 != deb) begin
                if (deb_cnt == DC_W'(DEB_CYC - 1)) begin
                    deb     <= step_s2;
                    deb_cnt <= '0;
                end else begin
                    deb_cnt <= deb_cnt + DC_W'(1);
                end
            end else begin
                deb_cnt <= '0;
            end
            deb_prev <= deb;
            step_ce  <= deb & ~deb_prev;
        end
    end

    // The step pulse is only visible in step mode, so a press in run mode is lost.
    assign cpu_ce  = step_mode ? step_ce : tick_ext[sel_cur];
    assign cpu_clk = step_mode ? deb : clk_ext[sel_cur];

endmodule

// File: tb/tb_clk_div_prog.sv
// Scoreboard bench for clk_div_prog: directed stimulus pushes the expected
// cpu_ce pulses (cycle and source) and a negedge monitor pops and compares.
module tb_clk_div_prog;

    localparam int CNT_W = 32;
    localparam int NCH   = 2;
    localparam int CH_W  = 1;
    localparam int DIV_W = 16;

    logic             clk;
    logic             rst_n;
    logic             cnt_en;
    logic             cfg_we;
    logic [CH_W-1:0]  cfg_ch;
    logic [DIV_W-1:0] cfg_div;
    logic [CH_W-1:0]  cpu_sel;
    logic             step_mode;
    logic             step;
    logic [CNT_W-1:0] clkdiv;
    logic [NCH-1:0]   ch_clk;
    logic [NCH-1:0]   ch_tick;
    logic             cpu_ce;
    logic             cpu_clk;
    logic [CH_W-1:0]  sel_cur;

    typedef struct {
        int              cyc;
        logic [CH_W-1:0] sel;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   cyc;
    int   total_cnt;
    int   pass_cnt;

    clk_div_prog #(
        .CNT_W    (CNT_W),
        .NCH      (NCH),
        .CH_W     (CH_W),
        .DIV_W    (DIV_W),
        .DIV_INIT (16'd3),
        .DEB_CYC  (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cnt_en    (cnt_en),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cpu_sel   (cpu_sel),
        .step_mode (step_mode),
        .step      (step),
        .clkdiv    (clkdiv),
        .ch_clk    (ch_clk),
        .ch_tick   (ch_tick),
        .cpu_ce    (cpu_ce),
        .cpu_clk   (cpu_clk),
        .sel_cur   (sel_cur)
    );

    // 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle index: value k is visible right after the k-th edge since reset release
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total_cnt++;
        if (actual === expected) pass_cnt++;
        else $display("[TB] FAIL %s: got %0d, want %0d (cycle %0d)", name, actual, expected, cyc);
    endtask

    task automatic applyStimulus(input logic we, input logic [CH_W-1:0] ch, input logic [DIV_W-1:0] dv);
        cfg_we  = we;
        cfg_ch  = ch;
        cfg_div = dv;
    endtask

    task automatic expectPulse(input int c, input logic [CH_W-1:0] s);
        exp_t e;
        e.cyc = c;
        e.sel = s;
        exp_q.push_back(e);
    endtask

    task automatic waitCycle(input int k);
        while (cyc < k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, "_clkdiv"},  clkdiv,  0);
        checkOutput({tag, "_ch_clk"},  ch_clk,  0);
        checkOutput({tag, "_ch_tick"}, ch_tick, 0);
        checkOutput({tag, "_cpu_ce"},  cpu_ce,  0);
        checkOutput({tag, "_cpu_clk"}, cpu_clk, 0);
        checkOutput({tag, "_sel_cur"}, sel_cur, 0);
    endtask

    // Monitor: every cpu_ce pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n === 1'b1 && cpu_ce === 1'b1) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("[TB] FAIL cpu_ce_unexpected: pulse at cycle %0d, none expected", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("cpu_ce_cycle", cyc, mon_e.cyc);
                checkOutput("cpu_ce_sel", sel_cur, mon_e.sel);
            end
        end
    end

    initial begin
        total_cnt = 0;
        pass_cnt  = 0;
        rst_n     = 1'b0;
        cnt_en    = 1'b0;
        cpu_sel   = '0;
        step_mode = 1'b0;
        step      = 1'b0;
        applyStimulus(1'b0, '0, '0);

        repeat (3) @(posedge clk);
        #1;
        checkReset("por");

        // Run-mode schedule: ch0 (D=3) until the switch, then ch1 (D=9)
        for (int k = 0; k <= 16; k++) expectPulse(4 + 8 * k, 1'b0);
        expectPulse(134, 1'b1);
        expectPulse(154, 1'b1);
        expectPulse(224, 1'b1);
        expectPulse(244, 1'b1);
        expectPulse(274, 1'b1);
        expectPulse(364, 1'b1);
        expectPulse(384, 1'b1);

        @(negedge clk);
        rst_n  = 1'b1;
        cnt_en = 1'b1;

        waitCycle(4);
        checkOutput("first_tick", ch_tick, 2'b11);
        waitCycle(100);
        checkOutput("clkdiv_100", clkdiv, 100);

        // ch1 reprogrammed during its high phase; the second write wins
        waitCycle(101);
        applyStimulus(1'b1, 1'b1, 16'd5);
        waitCycle(102);
        applyStimulus(1'b1, 1'b1, 16'd0);
        waitCycle(103);
        applyStimulus(1'b0, 1'b0, 16'd0);
        checkOutput("ch1_high_kept", ch_clk[1], 1);
        waitCycle(104);
        checkOutput("ch1_fall_104", ch_clk[1], 0);
        waitCycle(107);
        checkOutput("ch1_low_kept", ch_clk[1], 0);
        waitCycle(108);
        checkOutput("ch1_tick_108", ch_tick[1], 1);
        waitCycle(109);
        checkOutput("ch1_tick_109", ch_tick[1], 0);
        checkOutput("ch1_clk_109", ch_clk[1], 0);
        waitCycle(110);
        checkOutput("ch1_tick_110", ch_tick[1], 1);

        // ch1 to D=9, then request the switch to ch1
        waitCycle(112);
        applyStimulus(1'b1, 1'b1, 16'd9);
        waitCycle(113);
        applyStimulus(1'b0, 1'b0, 16'd0);
        waitCycle(114);
        checkOutput("ch1_tick_114", ch_tick[1], 1);
        waitCycle(118);
        cpu_sel = 1'b1;
        waitCycle(124);
        checkOutput("ch1_fall_124", ch_clk[1], 0);
        waitCycle(133);
        checkOutput("sel_before", sel_cur, 0);
        waitCycle(134);
        checkOutput("sel_after", sel_cur, 1);
        checkOutput("cpu_clk_134", cpu_clk, 1);

        // Freeze for 50 cycles
        waitCycle(160);
        cnt_en = 1'b0;
        waitCycle(185);
        checkOutput("frz_clkdiv", clkdiv, 160);
        checkOutput("frz_ch_clk", ch_clk, 2'b10);
        checkOutput("frz_ch_tick", ch_tick, 2'b00);
        waitCycle(210);
        checkOutput("frz_clkdiv_end", clkdiv, 160);
        cnt_en = 1'b1;
        waitCycle(214);
        checkOutput("resume_ch_tick", ch_tick, 2'b01);
        checkOutput("resume_ch_clk", ch_clk, 2'b01);
        waitCycle(220);
        checkOutput("resume_clkdiv", clkdiv, 170);

        // Step mode: one long press, then a short glitch
        waitCycle(250);
        step_mode = 1'b1;
        waitCycle(255);
        step = 1'b1;
        waitCycle(280);
        checkOutput("deb_high", cpu_clk, 1);
        waitCycle(295);
        step = 1'b0;
        waitCycle(320);
        checkOutput("deb_low", cpu_clk, 0);
        waitCycle(330);
        step = 1'b1;
        waitCycle(336);
        checkOutput("glitch_mid", cpu_clk, 0);
        waitCycle(340);
        step = 1'b0;
        waitCycle(350);
        checkOutput("glitch_after", cpu_clk, 0);

        // Press while in run mode is discarded
        waitCycle(360);
        step_mode = 1'b0;
        waitCycle(370);
        step = 1'b1;
        waitCycle(400);
        step_mode = 1'b1;
        waitCycle(401);
        checkOutput("deb_runmode_press", cpu_clk, 1);
        waitCycle(405);
        step = 1'b0;
        waitCycle(420);
        step_mode = 1'b0;

        // Pending write and pending switch, then reset mid-cycle
        waitCycle(422);
        cpu_sel = 1'b0;
        applyStimulus(1'b1, 1'b0, 16'd7);
        waitCycle(423);
        applyStimulus(1'b0, 1'b0, 16'd0);
        checkOutput("outstanding_run", exp_q.size(), 0);
        #2;
        rst_n = 1'b0;
        #1;
        checkReset("async");

        expectPulse(4, 1'b0);
        expectPulse(12, 1'b0);
        expectPulse(20, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        waitCycle(4);
        checkOutput("post_rst_tick", ch_tick, 2'b11);
        checkOutput("post_rst_sel", sel_cur, 0);
        waitCycle(24);
        checkOutput("outstanding_end", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/clk_div_prog.md
# clk_div_prog

Parametrised clock-enable generator for the CPU board top level. It keeps a free-running division counter and produces NCH independent square-wave channels with runtime-programmable periods. It generates a single-cycle CPU clock-enable pulse from the selected channel, switching between channels without glitches. A debug step mode emits exactly one debounced enable pulse per button press. Sits between the board clock buffer and the CPU/peripheral clock-enable inputs.

## Interface
- CNT_W, 32, width of free-running counter clkdiv
- NCH, 2, number of divider channels (2..8)
- CH_W, 1, width of channel index; NCH <= 2**CH_W
- DIV_W, 16, width of half-period divisor
- DIV_INIT, 16'd3, reset divisor loaded into every channel
- DEB_CYC, 16, cycles step must be stable before its debounced level changes (>=1)
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- cnt_en  in  1  global run enable (synchronous to clk)
- cfg_we  in  1  divisor write strobe
- cfg_ch  in  CH_W  channel index for write
- cfg_div  in  DIV_W  new half-period divisor D (half period = D+1 cycles)
- cpu_sel  in  CH_W  requested CPU source channel (synchronous)
- step_mode  in  1  1 = CPU enable from step button (synchronous)
- step  in  1  raw asynchronous push-button
- clkdiv  out  CNT_W  free-running count
- ch_clk  out  NCH  per-channel square wave
- ch_tick  out  NCH  per-channel one-cycle pulse, coincident with ch_clk rising
- cpu_ce  out  1  CPU clock enable, one-cycle pulses
- cpu_clk  out  1  monitor wave (LED): step_mode ? debounced step : ch_clk[sel_cur]
- sel_cur  out  CH_W  channel currently driving cpu_ce

## Operation
- Reset (rst_n=0, immediate): clkdiv=0, all channel counters=0, ch_clk=0, ch_tick=0, div[i]=DIV_INIT, no pending writes, sel_cur=0, cpu_ce=0, step synchronisers/debounce counter/debounced level=0.
- clkdiv: +1 per cycle while cnt_en=1; wraps modulo 2**CNT_W; holds when cnt_en=0.
- Channel i, while cnt_en=1: counter counts 0..div[i]. At terminal count it returns to 0 and ch_clk[i] toggles. ch_tick[i]=1 only in the cycle ch_clk[i] first reads 1. Period = 2*(div[i]+1). D=0 gives period 2 with tick every other cycle.
- cnt_en=0: channel counters and ch_clk frozen; ch_tick=0.
- Divisor write: cfg_we=1 with cfg_ch<NCH stores cfg_div as pending for that channel. cfg_ch>=NCH is ignored. A later write before apply overwrites (last wins).
- The pending value applies at the terminal count ending a low phase, so the new period starts exactly at a rising edge. High phase is never shortened or lengthened mid-period.
- Source select: when cpu_sel != sel_cur, sel_cur <= cpu_sel on the first cycle ch_tick[cpu_sel]=1. Requests change before that are tracked (latest cpu_sel wins). cpu_sel >= NCH is ignored (sel_cur held).
- Run mode (step_mode=0): cpu_ce = ch_tick[sel_cur] (combinational from registers). At most one pulse per cycle; no pulse lost or duplicated on switch.
- Step mode: step passes a 2-FF synchroniser. The debounced level changes only after the synchronised value differs from it for DEB_CYC consecutive cycles. Each debounced 0->1 edge gives exactly one cpu_ce pulse. ch_tick is excluded from cpu_ce in step mode. Step works regardless of cnt_en.
- A debounced rising edge while step_mode=0 is discarded, not queued.

## Timing
- After reset release with cnt_en=1, divisor D: ch_clk rises and ch_tick pulses on the (D+1)th rising clk edge, then every 2(D+1) cycles.
- Divisor write latency: takes effect at the next low-phase end (<= 2(D_old+1) cycles).
- Select switch latency: <= 2(D_new+1) cycles after cpu_sel changes.
- Step: the cpu_ce pulse occurs 2+DEB_CYC+1 cycles after the first clk edge sampling step=1 (±1 for async capture). It lasts exactly 1 cycle.
- Reset mid-period or mid-debounce: all state returns to reset values immediately; pending writes are lost.

## Test plan
- Reset, cnt_en=1, DIV_INIT=3 -> ch_tick[0] at cycle 4, then every 8 cycles; clkdiv=100 after 100 enabled cycles.
- Write ch1 D=0 mid high phase -> current period completes unchanged; next ch1 period = 2 cycles.
- cpu_sel 0->1 with D0=3, D1=9 -> sel_cur changes on the first ch_tick[1]; cpu_ce gaps are 8 before and 20 after; no double pulse.
- step_mode=1, DEB_CYC=16, step held high 40 cycles -> exactly one cpu_ce at ~cycle 19; 10-cycle glitches -> no pulse.
- cnt_en low for 50 cycles -> clkdiv, ch_clk frozen, no ticks; resume continues from the held count.
- rst_n low mid-operation with pending write and switch -> all outputs 0 and sel_cur=0 immediately; div back to DIV_INIT.
